// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl
// Description : Programmable clock divider with run/stop/single-step control
//               and a handshaked ratio update applied only on period boundaries.
// Revision    : 1.0
// ============================================================================
module clk_div_ctrl #(
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             out_clk,
  output logic             tick,
  output logic             running
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] C_MIN_DIV     = CNT_W'(2);
  localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [CNT_W-1:0] r_div_q, w_div_nx;
  logic [CNT_W-1:0] r_pend_div, w_pend_div_nx;
  logic             r_pend, w_pend_nx;
  logic             r_first, w_first_nx;
  logic             r_out_clk, w_out_clk_nx;
  logic             r_tick, w_tick_nx;
  logic             r_err, w_err_nx;
  logic             r_running;
  logic             w_xfer;
  logic             w_wrap;

  assign cfg_ready = ~r_pend;
  assign cfg_err   = r_err;
  assign out_clk   = r_out_clk;
  assign tick      = r_tick;
  assign running   = r_running;

  assign w_xfer = cfg_valid & ~r_pend;
  // r_first marks the lead-in cycle after leaving STOP; the period proper
  // begins with cnt = 0 on the following edge.
  assign w_wrap = ~r_first & (r_cnt == (r_div_q - C_ONE));

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_div_nx      = r_div_q;
    w_pend_div_nx = r_pend_div;
    w_pend_nx     = r_pend;
    w_first_nx    = r_first;
    w_out_clk_nx  = 1'b0;
    w_tick_nx     = 1'b0;
    w_err_nx      = 1'b0;

    case (r_state)
      ST_RUN, ST_STEP: begin
        if (r_first) begin
          w_cnt_nx   = '0;
          w_first_nx = 1'b0;
        end else if (w_wrap) begin
          w_cnt_nx = '0;
          if (r_pend) begin
            w_div_nx  = r_pend_div;
            w_pend_nx = 1'b0;
          end
          if ((r_state == ST_STEP) || !run) begin
            w_state_nx = ST_STOP;
          end
        end else begin
          w_cnt_nx = r_cnt + C_ONE;
        end
        if (w_state_nx != ST_STOP) begin
          w_out_clk_nx = (w_cnt_nx < (w_div_nx >> 1));
          w_tick_nx    = (w_cnt_nx == '0);
        end
      end
      default: begin
        w_cnt_nx = '0;
        if (run) begin
          w_state_nx = ST_RUN;
          w_first_nx = 1'b1;
        end else if (step) begin
          w_state_nx = ST_STEP;
          w_first_nx = 1'b1;
        end
      end
    endcase

    // A transfer can never coincide with a pending apply: ready implies !pend.
    if (w_xfer) begin
      if (cfg_div < C_MIN_DIV) begin
        w_err_nx = 1'b1;
      end else if (r_state == ST_STOP) begin
        w_div_nx = cfg_div;
      end else begin
        w_pend_div_nx = cfg_div;
        w_pend_nx     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_STOP;
      r_cnt      <= '0;
      r_div_q    <= C_DEFAULT_DIV;
      r_pend_div <= '0;
      r_pend     <= 1'b0;
      r_first    <= 1'b0;
      r_out_clk  <= 1'b0;
      r_tick     <= 1'b0;
      r_err      <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_div_q    <= w_div_nx;
      r_pend_div <= w_pend_div_nx;
      r_pend     <= w_pend_nx;
      r_first    <= w_first_nx;
      r_out_clk  <= w_out_clk_nx;
      r_tick     <= w_tick_nx;
      r_err      <= w_err_nx;
      r_running  <= (w_state_nx != ST_STOP);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_ctrl
// Description : Bench for clk_div_ctrl; a period-waveform model plus directed
//               literal checks and randomized run/step/config traffic.
// Revision    : 1.0
// ============================================================================
module tb_clk_div_ctrl;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        step;
  logic        cfg_valid;
  logic [31:0] cfg_div;
  logic        cfg_ready;
  logic        cfg_err;
  logic        out_clk;
  logic        tick;
  logic        running;

  int checks = 0;
  int errors = 0;

  clk_div_ctrl #(.CNT_W(32), .DEFAULT_DIV(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .step      (step),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .out_clk   (out_clk),
    .tick      (tick),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each period is a queued list of {out_clk,tick} samples; an empty
  // queue at an edge means the previous sample was the last of the period.
  int unsigned m_mode = 0;   // 0 stopped, 1 lead-in, 2 inside a period
  bit          m_step = 0;
  int unsigned m_div = 11;
  int unsigned m_pend_div = 0;
  bit          m_pend = 0;
  bit [1:0]    wave_q[$];
  bit          e_out = 0, e_tick = 0, e_err = 0, e_running = 0;
  bit          mx_xfer, mx_stopped;

  task automatic load_period();
    wave_q.delete();
    for (int unsigned i = 0; i < m_div; i++)
      wave_q.push_back({(i < m_div / 2), (i == 0)});
    {e_out, e_tick} = wave_q.pop_front();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_div = 11; m_pend = 0; wave_q.delete();
      e_out = 0; e_tick = 0; e_err = 0; e_running = 0;
    end else begin
      mx_xfer    = cfg_valid && !m_pend;
      mx_stopped = (m_mode == 0);
      e_err      = 0;
      case (m_mode)
        0: begin
          e_out = 0; e_tick = 0;
          if (run) begin m_mode = 1; m_step = 0; end
          else if (step) begin m_mode = 1; m_step = 1; end
        end
        1: begin
          load_period();
          m_mode = 2;
        end
        default: begin
          if (wave_q.size() != 0) begin
            {e_out, e_tick} = wave_q.pop_front();
          end else begin
            if (m_pend) begin m_div = m_pend_div; m_pend = 0; end
            if (m_step || !run) begin
              m_mode = 0; e_out = 0; e_tick = 0;
            end else begin
              load_period();
            end
          end
        end
      endcase
      if (mx_xfer) begin
        if (cfg_div < 2) e_err = 1;
        else if (mx_stopped) m_div = cfg_div;
        else begin m_pend_div = cfg_div; m_pend = 1; end
      end
      e_running = (m_mode != 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("m_out_clk",   {31'd0, out_clk},   {31'd0, e_out});
      chk("m_tick",      {31'd0, tick},      {31'd0, e_tick});
      chk("m_running",   {31'd0, running},   {31'd0, e_running});
      chk("m_cfg_ready", {31'd0, cfg_ready}, {31'd0, !m_pend});
      chk("m_cfg_err",   {31'd0, cfg_err},   {31'd0, e_err});
    end
  end

  task automatic measure(input int n, output int highs, output int ticks);
    highs = 0; ticks = 0;
    for (int i = 0; i < n; i++) begin
      highs += int'(out_clk);
      ticks += int'(tick);
      @(negedge clk);
    end
  endtask

  task automatic wait_tick(input int lim, output int cyc);
    cyc = 0;
    while (!tick && cyc < lim) begin @(negedge clk); cyc++; end
    chk("wait_tick_bound", {31'd0, tick}, 32'd1);
  endtask

  task automatic wait_stop(input int lim, output int cyc);
    cyc = 0;
    while (running && cyc < lim) begin @(negedge clk); cyc++; end
    chk("wait_stop_bound", {31'd0, running}, 32'd0);
  endtask

  task automatic single_step(input int n, input int exp_highs);
    int h, t;
    step = 1; @(negedge clk);
    step = 0; @(negedge clk);
    chk("step_first_tick", {31'd0, tick}, 32'd1);
    measure(n, h, t);
    chk("step_highs", h, exp_highs);
    chk("step_ticks", t, 1);
    chk("step_ends_stopped", {31'd0, running}, 32'd0);
  endtask

  initial begin
    int h, t, cyc, r;
    rst_n = 0; run = 0; step = 0; cfg_valid = 0; cfg_div = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_out_clk", {31'd0, out_clk}, 0);
    chk("rst_tick", {31'd0, tick}, 0);
    chk("rst_running", {31'd0, running}, 0);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 1);
    chk("rst_cfg_err", {31'd0, cfg_err}, 0);

    // Illegal ratios in STOP.
    cfg_valid = 1; cfg_div = 1; @(negedge clk);
    chk("err_div1", {31'd0, cfg_err}, 1);
    chk("err_div1_ready", {31'd0, cfg_ready}, 1);
    cfg_div = 0; @(negedge clk);
    chk("err_div0", {31'd0, cfg_err}, 1);
    cfg_valid = 0; @(negedge clk);
    chk("err_clears", {31'd0, cfg_err}, 0);

    // Free run at the default ratio.
    run = 1; @(negedge clk);
    chk("start_running", {31'd0, running}, 1);
    chk("start_no_tick_yet", {31'd0, tick}, 0);
    @(negedge clk);
    chk("start_tick", {31'd0, tick}, 1);
    chk("start_out_clk", {31'd0, out_clk}, 1);
    measure(11, h, t);
    chk("div11_highs", h, 5);
    chk("div11_ticks", t, 1);
    chk("div11_next_tick", {31'd0, tick}, 1);

    // Retune to 4 mid-period.
    repeat (3) @(negedge clk);
    cfg_valid = 1; cfg_div = 4; @(negedge clk);
    cfg_valid = 0;
    chk("stage_ready_low", {31'd0, cfg_ready}, 0);
    wait_tick(20, cyc);
    chk("stage_wait", cyc, 7);
    chk("stage_ready_back", {31'd0, cfg_ready}, 1);
    measure(4, h, t);
    chk("div4_highs", h, 2);
    chk("div4_ticks", t, 1);
    chk("div4_next_tick", {31'd0, tick}, 1);
    run = 0;
    wait_stop(20, cyc);
    chk("stop_out_low", {31'd0, out_clk}, 0);

    // Single step at N=6, with a stray step mid-period.
    cfg_valid = 1; cfg_div = 6; @(negedge clk);
    cfg_valid = 0;
    chk("stop_load_ready", {31'd0, cfg_ready}, 1);
    step = 1; @(negedge clk);
    step = 0; @(negedge clk);
    chk("step6_tick", {31'd0, tick}, 1);
    h = 0; t = 0;
    for (int c = 0; c < 6; c++) begin
      h += int'(out_clk); t += int'(tick);
      step = (c == 2);
      @(negedge clk);
    end
    step = 0;
    chk("step6_highs", h, 3);
    chk("step6_ticks", t, 1);
    chk("step6_stopped", {31'd0, running}, 0);
    chk("step6_out_low", {31'd0, out_clk}, 0);
    repeat (2) @(negedge clk);
    chk("step6_stray_ignored", {31'd0, running}, 0);

    // Stop with a staged ratio of 8.
    cfg_valid = 1; cfg_div = 11; @(negedge clk);
    cfg_valid = 0;
    run = 1;
    wait_tick(5, cyc);
    repeat (2) @(negedge clk);
    run = 0; cfg_valid = 1; cfg_div = 8; @(negedge clk);
    cfg_valid = 0;
    wait_stop(20, cyc);
    chk("drain_len", cyc, 8);
    chk("drain_out_low", {31'd0, out_clk}, 0);
    chk("drain_ready", {31'd0, cfg_ready}, 1);
    single_step(8, 4);

    // Asynchronous reset mid-period with a ratio pending.
    run = 1;
    wait_tick(5, cyc);
    @(negedge clk);
    cfg_valid = 1; cfg_div = 5; @(negedge clk);
    cfg_valid = 0;
    chk("pre_rst_ready", {31'd0, cfg_ready}, 0);
    chk("pre_rst_out", {31'd0, out_clk}, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_out", {31'd0, out_clk}, 0);
    chk("async_rst_running", {31'd0, running}, 0);
    chk("async_rst_ready", {31'd0, cfg_ready}, 1);
    run = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    single_step(11, 5);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      step = ($urandom_range(0, 9) == 0);
      cfg_valid = ($urandom_range(0, 5) == 0);
      r = int'($urandom_range(0, 9));
      cfg_div = (r < 2) ? 32'(r) : 32'($urandom_range(2, 12));
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 0;
        #1 rst_n = 1;
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
